regfile_mp: RTL and testbench

- Multi-ported, parametrised general-purpose register file; next generation of the single-write, two-read MIPS register file.
- Adds configurable read and write port counts, an optional hardwired-zero register and optional write-to-read bypass.
- Adds a per-register pending scoreboard for long-latency producers (loads, mult/div) and a reset-cleared storage array.
- Sits between decode (read ports, reserve) and writeback (write ports) in the core pipeline.

---
 rtl/regfile_mp_pkg.sv | 17 +
 rtl/regfile_mp_sb.sv | 62 ++++++
 rtl/regfile_mp.sv | 92 +++++++++
 tb/tb_regfile_mp.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared definitions for the multi-ported register file.
//   RF_ADDR_WIDTH / RF_DATA_WIDTH : default address and data widths
//   REG_ZERO                      : address of the optional hardwired-zero register
//   sb_op_e                       : per-entry scoreboard update selected each cycle
package regfile_mp_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned REG_ZERO      = 0;

  typedef enum logic [1:0] {
    SB_HOLD,
    SB_CLEAR,
    SB_SET
  } sb_op_e;

endpackage

// File: rtl/regfile_mp_sb.sv
// regfile_sb: pending-bit scoreboard, one bit per stored register entry.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   wr_en      : per-write-port enable; a write clears the target's pending bit
//   wr_addr    : packed write addresses, port j at [j*ADDR_WIDTH +: ADDR_WIDTH]
//   rsv_en     : reserve request; sets the pending bit of rsv_addr
//   rsv_addr   : register to reserve
//   pending    : pending bits indexed by entry (address - ZERO_REG)
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned WR_PORTS   = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [WR_PORTS-1:0]                   wr_en,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0]        wr_addr,
  input  logic                                  rsv_en,
  input  logic [ADDR_WIDTH-1:0]                 rsv_addr,
  output logic [(2**ADDR_WIDTH)-ZERO_REG-1:0]   pending
);

  localparam int unsigned N_ENT = (2**ADDR_WIDTH) - ZERO_REG;

  sb_op_e op [N_ENT];

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_WIDTH'(REG_ZERO));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ent_idx(input logic [ADDR_WIDTH-1:0] a);
    return a - ADDR_WIDTH'(ZERO_REG);
  endfunction

  // Reserve is applied after all clears so a new producer issued in the
  // same cycle as the completing write keeps the register pending.
  always_comb begin
    for (int unsigned e = 0; e < N_ENT; e++) op[e] = SB_HOLD;
    for (int unsigned j = 0; j < WR_PORTS; j++) begin
      if (wr_en[j] && !is_zero(wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]))
        op[ent_idx(wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH])] = SB_CLEAR;
    end
    if (rsv_en && !is_zero(rsv_addr))
      op[ent_idx(rsv_addr)] = SB_SET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int unsigned e = 0; e < N_ENT; e++) begin
        case (op[e])
          SB_SET:   pending[e] <= 1'b1;
          SB_CLEAR: pending[e] <= 1'b0;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-ported register file with pending scoreboard.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   rd_addr    : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data    : packed combinational read data
//   rd_busy    : 1 = addressed register still awaits its reserved producer
//   wr_en      : per-write-port enable (higher port index wins on conflicts)
//   wr_addr    : packed write addresses
//   wr_data    : packed write data
//   rsv_en     : reserve (mark pending) request from issue
//   rsv_addr   : register to reserve
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned RD_PORTS   = 2,
  parameter int unsigned WR_PORTS   = 1,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_busy,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr
);

  localparam int unsigned N_ENT = (2**ADDR_WIDTH) - ZERO_REG;

  logic [DATA_WIDTH-1:0] mem [N_ENT];
  logic [N_ENT-1:0]      pending;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_WIDTH'(REG_ZERO));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ent_idx(input logic [ADDR_WIDTH-1:0] a);
    return a - ADDR_WIDTH'(ZERO_REG);
  endfunction

  regfile_sb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WR_PORTS   (WR_PORTS),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pending  (pending)
  );

  // Ports are scanned in ascending order; the last non-blocking assignment
  // to an entry wins, giving the higher port index priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned e = 0; e < N_ENT; e++) mem[e] <= '0;
    end else begin
      for (int unsigned j = 0; j < WR_PORTS; j++) begin
        if (wr_en[j] && !is_zero(wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]))
          mem[ent_idx(wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH])] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < RD_PORTS; i++) begin
      if (!is_zero(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[ent_idx(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])];
        rd_busy[i] = pending[ent_idx(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])];
        if (BYPASS != 0) begin
          for (int unsigned j = 0; j < WR_PORTS; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
              rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
              rd_busy[i] = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: three regfile_mp configurations driven by one directed
// stimulus stream and checked against an address-level behavioural model.
//   c=0 : ZERO_REG=1, BYPASS=1
//   c=1 : ZERO_REG=1, BYPASS=0
//   c=2 : ZERO_REG=0, BYPASS=1
// All instances use two read and two write ports.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RP = 2;
  localparam int WP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [RP*AW-1:0] rd_addr;
  logic [WP-1:0]    wr_en;
  logic [WP*AW-1:0] wr_addr;
  logic [WP*DW-1:0] wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;

  logic [RP*DW-1:0] rdd [3];
  logic [RP-1:0]    rdb [3];

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem_m  [3][32];
  bit            pend_m [3][32];

  always #5 clk = ~clk;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PORTS(RP), .WR_PORTS(WP),
               .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_busy(rdb[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr));

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PORTS(RP), .WR_PORTS(WP),
               .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_busy(rdb[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr));

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PORTS(RP), .WR_PORTS(WP),
               .ZERO_REG(0), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd[2]), .rd_busy(rdb[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr));

  function automatic bit cfg_zr(int c);
    return c != 2;
  endfunction

  function automatic bit cfg_byp(int c);
    return c != 1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected read result for configuration c at address a, given the
  // architectural state and the writes presented this cycle.
  function automatic void exp_read(int c, logic [AW-1:0] a,
                                   output logic [DW-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (cfg_zr(c) && a == 0) return;
    d = mem_m[c][a];
    b = pend_m[c][a];
    if (cfg_byp(c)) begin
      for (int j = 0; j < WP; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
          d = wr_data[j*DW +: DW];
          b = 1'b0;
        end
      end
    end
  endfunction

  // Architectural state update
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 32; r++) begin
          mem_m[c][r]  = '0;
          pend_m[c][r] = 1'b0;
        end
    end else begin
      for (int c = 0; c < 3; c++) begin
        for (int j = 0; j < WP; j++) begin
          if (wr_en[j] && !(cfg_zr(c) && wr_addr[j*AW +: AW] == 0)) begin
            mem_m[c][wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
            pend_m[c][wr_addr[j*AW +: AW]] = 1'b0;
          end
        end
        if (rsv_en && !(cfg_zr(c) && rsv_addr == 0))
          pend_m[c][rsv_addr] = 1'b1;
      end
    end
  end

  // Per-cycle compare of every instance and read port against the model
  always @(negedge clk) begin
    logic [DW-1:0] d;
    logic          b;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < RP; i++) begin
        exp_read(c, rd_addr[i*AW +: AW], d, b);
        chk($sformatf("cmp c%0d p%0d data", c, i), rdd[c][i*DW +: DW], d);
        chk($sformatf("cmp c%0d p%0d busy", c, i), rdb[c][i], b);
      end
    end
  end

  task automatic lit(string nm, int c, int p, logic [DW-1:0] ed, logic eb);
    chk($sformatf("%s c%0d p%0d data", nm, c, p), rdd[c][p*DW +: DW], ed);
    chk($sformatf("%s c%0d p%0d busy", nm, c, p), rdb[c][p], eb);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic set_rd(logic [AW-1:0] a0, logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(int j, logic [AW-1:0] a, logic [DW-1:0] d);
    wr_en[j]           = 1'b1;
    wr_addr[j*AW +: AW] = a;
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_rsv(logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    idle();
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_addr = '0;

    #2 rst_n = 1'b0;
    #1;
    lit("in_reset", 2, 0, 32'h0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;

    // Reset state across the whole address space
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), AW'(31 - a));
      #1;
      for (int c = 0; c < 3; c++) begin
        lit("reset", c, 0, 32'h0, 1'b0);
        lit("reset", c, 1, 32'h0, 1'b0);
      end
      step();
    end

    // Basic write / read
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(5, 5);
    #1;
    lit("nobyp_old", 1, 0, 32'h0, 1'b0);
    step();
    idle();
    #1;
    lit("r5", 0, 0, 32'hDEADBEEF, 1'b0);
    lit("r5", 0, 1, 32'hDEADBEEF, 1'b0);
    lit("r5", 1, 0, 32'hDEADBEEF, 1'b0);
    step();

    // Write to r0
    set_wr(0, 0, 32'h1234);
    set_rd(0, 0);
    #1;
    lit("r0_byp", 0, 0, 32'h0, 1'b0);
    step();
    idle();
    #1;
    lit("r0_zero", 0, 0, 32'h0, 1'b0);
    lit("r0_zero", 1, 1, 32'h0, 1'b0);
    lit("r0_plain", 2, 0, 32'h1234, 1'b0);
    step();

    // Bypass vs. no bypass
    set_wr(0, 7, 32'hA5A5A5A5);
    set_rd(7, 0);
    #1;
    lit("byp_same", 0, 0, 32'hA5A5A5A5, 1'b0);
    lit("nobyp_same", 1, 0, 32'h0, 1'b0);
    step();
    idle();
    #1;
    lit("nobyp_next", 1, 0, 32'hA5A5A5A5, 1'b0);
    step();

    // Dual-write conflict: port 1 wins
    set_wr(0, 9, 32'h1);
    set_wr(1, 9, 32'h2);
    set_rd(9, 9);
    #1;
    lit("dual_byp", 0, 0, 32'h2, 1'b0);
    step();
    idle();
    #1;
    for (int c = 0; c < 3; c++) lit("dual", c, 1, 32'h2, 1'b0);
    step();

    // Scoreboard
    set_rsv(3);
    set_rd(3, 0);
    #1;
    lit("rsv_same", 0, 0, 32'h0, 1'b0);
    step();
    idle();
    #1;
    lit("rsv_next", 0, 0, 32'h0, 1'b1);
    lit("rsv_next", 1, 0, 32'h0, 1'b1);
    set_wr(1, 3, 32'h55);
    #1;
    lit("clr_byp", 0, 0, 32'h55, 1'b0);
    lit("clr_nobyp", 1, 0, 32'h0, 1'b1);
    step();
    idle();
    #1;
    lit("clr_next", 0, 0, 32'h55, 1'b0);
    lit("clr_next", 1, 0, 32'h55, 1'b0);
    set_rsv(3);
    set_wr(0, 3, 32'h66);
    #1;
    lit("rsvwr_byp", 0, 0, 32'h66, 1'b0);
    lit("rsvwr_nobyp", 1, 0, 32'h55, 1'b0);
    step();
    idle();
    #1;
    lit("rsvwr_next", 0, 0, 32'h66, 1'b1);
    lit("rsvwr_next", 1, 0, 32'h66, 1'b1);
    set_rsv(3);
    step();
    idle();
    #1;
    lit("rsv_again", 0, 0, 32'h66, 1'b1);
    set_rsv(0);
    set_rd(0, 5);
    step();
    idle();
    #1;
    lit("rsv_r0", 0, 0, 32'h0, 1'b0);
    lit("rsv_r0", 2, 0, 32'h1234, 1'b1);
    lit("r5_idle", 0, 1, 32'hDEADBEEF, 1'b0);

    // Async reset between clock edges
    set_wr(0, 4, 32'h77);
    set_rsv(4);
    set_rd(4, 3);
    step();
    idle();
    #1;
    lit("r4_set", 0, 0, 32'h77, 1'b1);
    lit("r4_set", 1, 0, 32'h77, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      lit("async_rst", c, 0, 32'h0, 1'b0);
      lit("async_rst", c, 1, 32'h0, 1'b0);
    end
    #2 rst_n = 1'b1;
    #1;
    lit("after_rst", 0, 0, 32'h0, 1'b0);
    step();

    // First edge after reset release takes effect normally
    set_wr(1, 10, 32'hCAFE);
    set_rsv(11);
    set_rd(10, 11);
    step();
    idle();
    #1;
    lit("post_rst", 0, 0, 32'hCAFE, 1'b0);
    lit("post_rst", 0, 1, 32'h0, 1'b1);
    lit("post_rst", 1, 1, 32'h0, 1'b1);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
